seg_reader: RTL and testbench
=============================

SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical cycles required before a digit pattern is captured.
REQ-002 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 Port seg, input, 7: active-low segment bus of a 4-digit multiplexed display; bit 6 = g ... bit 0 = a.
REQ-005 Port dig_sel, input, 4: active-low digit enables; dig_sel[0] = digit 0 = least significant nibble.
REQ-006 Port value, output, 16: last complete decoded frame; digit n occupies bits 4n+3..4n.
REQ-007 Port valid, output, 1: value holds an unconsumed frame.
REQ-008 Port ready, input, 1: consumer accepts value when valid and ready are both high.
REQ-009 Port err, output, 1: one-cycle pulse on frame abort.
REQ-010 Port overrun, output, 1: one-cycle pulse when an unconsumed frame is overwritten.
REQ-011 Port blank, output, 4: per-digit blank flags of the last frame.

Function
REQ-012 Decode table (seg -> nibble), the only legal patterns:
- 1000000->0, 1111001->1, 0100100->2, 0110000->3
- 0011001->4, 0010010->5, 0000010->6, 1111000->7
- 0000000->8, 0010000->9, 0001000->A, 0000011->B
- 1000110->C, 0100001->D, 0000110->E, 0001110->F
REQ-013 A digit is selected only when exactly one dig_sel bit is low; any other dig_sel value is a gap and resets the settle counter.
REQ-014 States: IDLE, SETTLE, CAPTURED, DONE.
REQ-015 IDLE: advance to SETTLE when digit 0 is selected; ignore all other digits.
REQ-016 SETTLE: count cycles with seg and dig_sel unchanged from the previous cycle; any change restarts the count at 1.
REQ-017 SETTLE: capture on the cycle the count reaches STABLE_CYCLES, then go to CAPTURED.
REQ-018 CAPTURED: wait for dig_sel to change. A gap stays in CAPTURED. Selection of (captured digit + 1) enters SETTLE. Selection of any other digit aborts the frame.
REQ-019 An illegal pattern at capture time aborts the frame.
REQ-020 Abort: err high for one cycle, partial nibbles discarded, return to IDLE; value, blank and valid are unchanged.
REQ-021 Capture of digit 3 enters DONE. The next cycle loads value and blank, sets valid, and returns to IDLE. Latency is 1 cycle from the digit-3 capture.
REQ-022 Handshake: valid clears the cycle after valid and ready are both high.
REQ-023 A frame load in the same cycle as an accept keeps valid high with the new value; overrun stays low.
REQ-024 A frame load while valid is high and ready is low overwrites value and pulses overrun for one cycle.
REQ-025 value and blank are stable while valid is high, except on a frame load.

Reset
REQ-026 When reset_n is low: state = IDLE, value = 0, blank = 0, valid = 0, err = 0, overrun = 0, settle counter = 0, partial frame cleared.
REQ-027 Reset mid-frame discards the frame. After reset_n deasserts, capture restarts only at the next digit-0 selection.

Configuration
REQ-028 Macro SEG_READER_BLANK_EN.
- Defined: pattern 1111111 is legal, decodes to nibble 0 and sets that digit's blank bit.
- Undefined: 1111111 is illegal (aborts the frame per REQ-019) and blank is tied to 0.

Verification
REQ-029 Scan the digits 0..3 in order, each held 4 cycles, showing 3,0,F,C (patterns 0110000, 1000000, 0001110, 1000110) -> value = 16'hCF03, valid high 1 cycle after the digit-3 capture, err = 0.
REQ-030 Digit 1 holds 3 cycles, with seg toggling on the second cycle -> no capture; holding digit 1 for 4 further stable cycles -> capture; frame completes normally.
REQ-031 Scan 0,2 (digit 1 skipped) -> err pulses once; value and valid unchanged; the next ordered scan produces a correct frame.
REQ-032 Digit 2 shows 0101010 -> err pulse, no frame. With SEG_READER_BLANK_EN, digit 2 = 1111111 -> value nibble 2 = 0 and blank = 4'b0100. Without the macro, digit 2 = 1111111 -> err pulse.
REQ-033 With ready held low, two frames 16'h1234 then 16'h5678 -> overrun pulses once, value = 16'h5678; raising ready -> valid clears next cycle.
REQ-034 Assert reset_n low during digit 2 of a frame -> all outputs 0 immediately; a following full scan yields a correct frame.

Source files
------------

// File: rtl/seg_reader.sv
// seg_reader: captures the digits of a 4-digit multiplexed 7-segment
// display (active-low segments and digit enables) and presents each
// complete ordered scan as a 16-bit frame with a valid/ready handshake.
// Optional feature macro: SEG_READER_BLANK_EN (all-segments-off pattern is
// accepted as a blank digit and reported on the blank output).
module seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
  output logic [15:0] value,
  output logic        valid,
  input  logic        ready,
  output logic        err,
  output logic        overrun,
  output logic [3:0]  blank
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURED, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic [1:0]      r_digit, w_digit_nxt;
  logic [6:0]      r_prev_seg;
  logic [3:0]      r_prev_sel;
  logic [3:0][3:0] r_partial;
  logic [15:0]     r_value;
  logic            r_valid, r_err, r_ovr;

  logic            w_legal;
  logic [3:0]      w_nib;
  logic            w_blank_pat;
  logic            w_sel_vld;
  logic [1:0]      w_sel_idx;
  logic            w_stable;
  logic [8:0]      w_cnt_inc;
  logic            w_start, w_capture, w_abort, w_load;

  // Segment pattern to nibble; anything outside the table is illegal.
  always_comb begin
    w_legal     = 1'b1;
    w_nib       = 4'h0;
    w_blank_pat = 1'b0;
    case (seg)
      7'b1000000: w_nib = 4'h0;
      7'b1111001: w_nib = 4'h1;
      7'b0100100: w_nib = 4'h2;
      7'b0110000: w_nib = 4'h3;
      7'b0011001: w_nib = 4'h4;
      7'b0010010: w_nib = 4'h5;
      7'b0000010: w_nib = 4'h6;
      7'b1111000: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0010000: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b0000011: w_nib = 4'hB;
      7'b1000110: w_nib = 4'hC;
      7'b0100001: w_nib = 4'hD;
      7'b0000110: w_nib = 4'hE;
      7'b0001110: w_nib = 4'hF;
`ifdef SEG_READER_BLANK_EN
      7'b1111111: w_blank_pat = 1'b1;
`endif
      default:    w_legal = 1'b0;
    endcase
  end

  // A digit counts as selected only when exactly one enable is low.
  always_comb begin
    w_sel_vld = 1'b1;
    w_sel_idx = 2'd0;
    case (dig_sel)
      4'b1110: w_sel_idx = 2'd0;
      4'b1101: w_sel_idx = 2'd1;
      4'b1011: w_sel_idx = 2'd2;
      4'b0111: w_sel_idx = 2'd3;
      default: w_sel_vld = 1'b0;
    endcase
  end

  assign w_stable  = (seg == r_prev_seg) && (dig_sel == r_prev_sel);
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

  // Next-state logic: settle counting, capture/abort decisions, frame load.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_digit_nxt = r_digit;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 8'd0;
        // the selection cycle itself is the first counted cycle
        if (w_sel_vld && w_sel_idx == 2'd0) begin
          w_state_nxt = S_SETTLE;
          w_digit_nxt = 2'd0;
          w_cnt_nxt   = 8'd1;
          w_start     = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!w_sel_vld) begin
          w_cnt_nxt = 8'd0;
        end else if (w_sel_idx != r_digit) begin
          w_abort = 1'b1;
        end else if (!w_stable) begin
          w_cnt_nxt = 8'd1;
        end else if (w_cnt_inc == 9'(STABLE_CYCLES)) begin
          w_cnt_nxt = 8'd0;
          if (!w_legal) begin
            w_abort = 1'b1;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = (r_digit == 2'd3) ? S_DONE : S_CAPTURED;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc[7:0];
        end
      end
      S_CAPTURED: begin
        w_cnt_nxt = 8'd0;
        // same digit still held: keep waiting; gaps are ignored
        if (w_sel_vld && w_sel_idx == r_digit + 2'd1) begin
          w_state_nxt = S_SETTLE;
          w_digit_nxt = r_digit + 2'd1;
          w_cnt_nxt   = 8'd1;
        end else if (w_sel_vld && (w_sel_idx != r_digit || dig_sel != r_prev_sel)) begin
          w_abort = 1'b1;
        end
      end
      S_DONE: begin
        w_load      = 1'b1;
        w_cnt_nxt   = 8'd0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 8'd0;
    end
  end

  // State, settle counter and previous-cycle input history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_digit    <= 2'd0;
      r_prev_seg <= 7'h7F;
      r_prev_sel <= 4'hF;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_digit    <= w_digit_nxt;
      r_prev_seg <= seg;
      r_prev_sel <= dig_sel;
    end
  end

  // Partial frame: cleared on frame start/abort, one nibble per capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_partial <= '0;
    end else if (w_start || w_abort) begin
      r_partial <= '0;
    end else if (w_capture) begin
      r_partial[r_digit] <= w_nib;
    end
  end

  // Output frame, handshake and event pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= 16'h0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_err <= w_abort;
      r_ovr <= w_load && r_valid && !ready;
      if (w_load) begin
        r_value <= r_partial;
        r_valid <= 1'b1;
      end else if (ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SEG_READER_BLANK_EN
  logic [3:0] r_pblank;
  logic [3:0] r_blank;

  // Per-digit blank flags travel with the partial frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pblank <= 4'h0;
      r_blank  <= 4'h0;
    end else begin
      if (w_start || w_abort)
        r_pblank <= 4'h0;
      else if (w_capture)
        r_pblank[r_digit] <= w_blank_pat;
      if (w_load)
        r_blank <= r_pblank;
    end
  end

  assign blank = r_blank;
`else
  assign blank = 4'h0;
`endif

  assign value   = r_value;
  assign valid   = r_valid;
  assign err     = r_err;
  assign overrun = r_ovr;

endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader with STABLE_CYCLES = 4: ordered scans,
// glitch/restart, skipped digit, illegal/blank patterns, overrun,
// same-cycle load+accept and asynchronous reset mid-frame.
module tb_seg_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  dig_sel = 4'hF;
  logic        ready = 1'b0;
  logic [15:0] value;
  logic        valid, err, overrun;
  logic [3:0]  blank;

  localparam logic [3:0] GAP = 4'hF;

  int n_chk = 0;
  int n_err = 0;
  int n_errp = 0;
  int n_ovr = 0;
  int e0, o0;
  logic [6:0] pat [16];

  seg_reader #(.STABLE_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .seg(seg), .dig_sel(dig_sel),
    .value(value), .valid(valid), .ready(ready), .err(err),
    .overrun(overrun), .blank(blank)
  );

  always #5 clock = ~clock;

  // pulse-width counters, sampled mid-cycle
  always @(negedge clock) begin
    if (err) n_errp++;
    if (overrun) n_ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sel(input int d);
    logic [3:0] m;
    m = 4'b0001 << d;
    return ~m;
  endfunction

  task automatic cyc(input logic [6:0] s, input logic [3:0] d);
    seg = s;
    dig_sel = d;
    @(posedge clock);
    #1;
  endtask

  task automatic dig(input int d, input logic [6:0] s, input int n);
    repeat (n) cyc(s, sel(d));
  endtask

  task automatic scanp(input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] c, input logic [6:0] d);
    dig(0, a, 4); dig(1, b, 4); dig(2, c, 4); dig(3, d, 4);
  endtask

  task automatic scan(input logic [15:0] v);
    scanp(pat[v[3:0]], pat[v[7:4]], pat[v[11:8]], pat[v[15:12]]);
  endtask

  task automatic accept();
    ready = 1'b1;
    cyc(7'h7F, GAP);
    ready = 1'b0;
  endtask

  initial begin
    pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100; pat[3] = 7'b0110000;
    pat[4] = 7'b0011001; pat[5] = 7'b0010010; pat[6] = 7'b0000010; pat[7] = 7'b1111000;
    pat[8] = 7'b0000000; pat[9] = 7'b0010000; pat[10] = 7'b0001000; pat[11] = 7'b0000011;
    pat[12] = 7'b1000110; pat[13] = 7'b0100001; pat[14] = 7'b0000110; pat[15] = 7'b0001110;

    // reset state with live inputs
    dig(0, pat[1], 3);
    chk("rst_value", value, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_blank", blank, 0);
    reset_n = 1'b1;
    cyc(7'h7F, GAP);

    // basic frame 3,0,F,C: valid one cycle after the digit-3 capture
    scanp(7'b0110000, 7'b1000000, 7'b0001110, 7'b1000110);
    chk("f1_valid_at_cap", valid, 0);
    cyc(7'h7F, GAP);
    chk("f1_valid", valid, 1);
    chk("f1_value", value, 16'hCF03);
    chk("f1_blank", blank, 0);
    cyc(7'h7F, GAP);
    chk("f1_valid_hold", valid, 1);
    chk("f1_errp", n_errp, 0);
    accept();
    chk("f1_accept", valid, 0);
    chk("f1_value_kept", value, 16'hCF03);

    // glitch on digit 1 restarts the settle count
    dig(0, pat[1], 4);
    cyc(pat[2], sel(1)); cyc(pat[5], sel(1)); cyc(pat[2], sel(1));
    dig(1, pat[2], 4);
    dig(2, pat[3], 4);
    dig(3, pat[4], 4);
    cyc(7'h7F, GAP);
    chk("f2_valid", valid, 1);
    chk("f2_value", value, 16'h4321);
    cyc(7'h7F, GAP);
    chk("f2_errp", n_errp, 0);
    chk("f2_ovr", n_ovr, 0);
    accept();

    // skipped digit aborts; next ordered scan is fine
    e0 = n_errp;
    dig(0, pat[5], 4);
    dig(2, pat[6], 4);
    cyc(7'h7F, GAP);
    chk("skip_errp", n_errp - e0, 1);
    chk("skip_valid", valid, 0);
    chk("skip_value", value, 16'h4321);
    scan(16'hEDBA);
    cyc(7'h7F, GAP);
    chk("f3_valid", valid, 1);
    chk("f3_value", value, 16'hEDBA);
    accept();

    // illegal pattern on digit 2
    e0 = n_errp;
    scanp(pat[1], pat[2], 7'b0101010, pat[3]);
    cyc(7'h7F, GAP);
    chk("ill_errp", n_errp - e0, 1);
    chk("ill_valid", valid, 0);
    chk("ill_value", value, 16'hEDBA);

    // all-segments-off on digit 2
    e0 = n_errp;
    scanp(pat[7], pat[8], 7'b1111111, pat[9]);
    cyc(7'h7F, GAP);
`ifdef SEG_READER_BLANK_EN
    chk("blk_valid", valid, 1);
    chk("blk_value", value, 16'h9087);
    chk("blk_blank", blank, 4'b0100);
    cyc(7'h7F, GAP);
    chk("blk_errp", n_errp - e0, 0);
    accept();
`else
    chk("blk_valid", valid, 0);
    chk("blk_value", value, 16'hEDBA);
    chk("blk_blank", blank, 4'b0000);
    cyc(7'h7F, GAP);
    chk("blk_errp", n_errp - e0, 1);
`endif

    // overrun with ready held low
    o0 = n_ovr;
    scan(16'h1234);
    cyc(7'h7F, GAP);
    chk("ov_a_value", value, 16'h1234);
    chk("ov_a_valid", valid, 1);
    scan(16'h5678);
    cyc(7'h7F, GAP);
    cyc(7'h7F, GAP);
    chk("ov_b_value", value, 16'h5678);
    chk("ov_b_valid", valid, 1);
    chk("ov_b_pulses", n_ovr - o0, 1);

    // load in the same cycle as an accept: no overrun, valid stays
    o0 = n_ovr;
    scan(16'hABCD);
    ready = 1'b1;
    cyc(7'h7F, GAP);
    chk("la_valid", valid, 1);
    chk("la_value", value, 16'hABCD);
    cyc(7'h7F, GAP);
    chk("la_clear", valid, 0);
    ready = 1'b0;
    chk("la_ovr", n_ovr - o0, 0);

    // asynchronous reset during digit 2, then a clean frame
    dig(0, pat[1], 4);
    dig(1, pat[2], 4);
    dig(2, pat[3], 2);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_value", value, 0);
    chk("ar_valid", valid, 0);
    chk("ar_blank", blank, 0);
    chk("ar_err", err, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    e0 = n_errp;
    dig(2, pat[3], 2);
    dig(3, pat[4], 4);
    cyc(7'h7F, GAP);
    chk("ar_no_frame", valid, 0);
    scan(16'h2468);
    cyc(7'h7F, GAP);
    chk("ar_f_valid", valid, 1);
    chk("ar_f_value", value, 16'h2468);
    chk("ar_errp", n_errp - e0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
